lsu_dtcm_responder: RTL and testbench

//  Responder end of the IQ->LSU request / LSU->IQ response handshake.

---
 rtl/lsu_dtcm_responder.sv | 145 ++++++++++++++
 tb/tb_lsu_dtcm_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dtcm_responder.sv
// LSU data-side responder: executes IQ load/store requests against a word-organised
// tightly coupled data memory and returns one in-order response per accepted request.

package lsu_dtcm_pkg;

    typedef struct packed {
        logic [3:0]  wid;
        logic        msigned;
        logic [1:0]  msize;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [3:0]  rmask;
        logic [3:0]  strb;
    } iq_lsu_pkg_t;

    typedef struct packed {
        logic        execute_exception;
        logic [5:0]  exc_code;
        logic [31:0] badv;
    } exc_info_t;

    typedef struct packed {
        logic [3:0]  wid;
        logic [31:0] rdata;
        exc_info_t   execute_exc_info;
    } lsu_iq_pkg_t;

endpackage

module lsu_dtcm_responder
    import lsu_dtcm_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [5:0]  EXC_ALE   = 6'h09,
    parameter logic [5:0]  EXC_ADE   = 6'h08
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        iq_lsu_valid_i,
    output logic        iq_lsu_ready_o,
    input  iq_lsu_pkg_t iq_lsu_req_i,
    output logic        lsu_iq_valid_o,
    input  logic        lsu_iq_ready_i,
    output lsu_iq_pkg_t lsu_iq_resp_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    logic [31:0] mem_r [MEM_WORDS];
    logic        resp_valid_r;
    lsu_iq_pkg_t resp_r;

    logic          accept_s;
    logic          is_store_s;
    logic          ale_s;
    logic          ade_s;
    logic          wr_en_s;
    logic [31:0]   off_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   word_s;
    logic [31:0]   shifted_s;
    logic [31:0]   load_data_s;
    lsu_iq_pkg_t   resp_next_s;
    logic          unused_req_s;

    // One-entry pipeline: ready depends only on the held response and the consumer.
    assign iq_lsu_ready_o = !resp_valid_r || lsu_iq_ready_i;
    assign accept_s       = iq_lsu_valid_i && iq_lsu_ready_o;
    assign wr_en_s        = accept_s && is_store_s && !ale_s && !ade_s;
    assign lsu_iq_valid_o = resp_valid_r;
    assign lsu_iq_resp_o  = resp_r;
    assign unused_req_s   = ^{iq_lsu_req_i.wid, iq_lsu_req_i.rmask, off_s[1:0], shifted_s[31:16]};

    // Request decode, exception check and combinational memory read.
    always_comb begin
        off_s       = iq_lsu_req_i.vaddr - ADDR_BASE;
        idx_s       = off_s[AW+1:2];
        is_store_s  = |iq_lsu_req_i.strb;
        ade_s       = |off_s[31:AW+2];
        word_s      = mem_r[idx_s];
        shifted_s   = word_s >> {iq_lsu_req_i.vaddr[1:0], 3'b000};
        resp_next_s = '0;
        case (iq_lsu_req_i.msize)
            2'd0:    ale_s = 1'b0;
            2'd1:    ale_s = iq_lsu_req_i.vaddr[0];
            default: ale_s = |iq_lsu_req_i.vaddr[1:0];
        endcase
        case (iq_lsu_req_i.msize)
            2'd0:    load_data_s = extend_byte(shifted_s[7:0], iq_lsu_req_i.msigned);
            2'd1:    load_data_s = extend_half(shifted_s[15:0], iq_lsu_req_i.msigned);
            default: load_data_s = word_s;
        endcase
        // Misalignment outranks an out-of-range address.
        if (ale_s) begin
            resp_next_s.execute_exc_info.execute_exception = 1'b1;
            resp_next_s.execute_exc_info.exc_code          = EXC_ALE;
            resp_next_s.execute_exc_info.badv              = iq_lsu_req_i.vaddr;
        end else if (ade_s) begin
            resp_next_s.execute_exc_info.execute_exception = 1'b1;
            resp_next_s.execute_exc_info.exc_code          = EXC_ADE;
            resp_next_s.execute_exc_info.badv              = iq_lsu_req_i.vaddr;
        end else if (!is_store_s) begin
            resp_next_s.rdata = load_data_s;
        end else begin
            resp_next_s.rdata = 32'h0000_0000;
        end
    end

    // Byte-lane store into the data memory; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int k = 0; k < 4; k++) begin
                if (iq_lsu_req_i.strb[k]) begin
                    mem_r[idx_s][8*k +: 8] <= iq_lsu_req_i.wdata[8*k +: 8];
                end
            end
        end
    end

    // Response register: flush drops it, an accept reloads it, a handshake retires it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
            resp_r       <= '0;
        end else if (flush) begin
            resp_valid_r <= 1'b0;
        end else if (accept_s) begin
            resp_valid_r <= 1'b1;
            resp_r       <= resp_next_s;
        end else if (lsu_iq_ready_i) begin
            resp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_dtcm_responder.sv
// Randomised bench for lsu_dtcm_responder against a byte-addressed reference model.

module tb_lsu_dtcm_responder;
    import lsu_dtcm_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        iq_lsu_valid_i;
    logic        iq_lsu_ready_o;
    iq_lsu_pkg_t iq_lsu_req_i;
    logic        lsu_iq_valid_o;
    logic        lsu_iq_ready_i;
    lsu_iq_pkg_t lsu_iq_resp_o;

    int checks = 0;
    int errors = 0;

    byte unsigned mdl_mem [MEM_BYTES];
    lsu_iq_pkg_t  exp_q [$];
    lsu_iq_pkg_t  last_resp;

    lsu_dtcm_responder #(
        .MEM_WORDS(MEM_WORDS),
        .ADDR_BASE(ADDR_BASE),
        .EXC_ALE  (6'h09),
        .EXC_ADE  (6'h08)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .iq_lsu_valid_i(iq_lsu_valid_i),
        .iq_lsu_ready_o(iq_lsu_ready_o),
        .iq_lsu_req_i  (iq_lsu_req_i),
        .lsu_iq_valid_o(lsu_iq_valid_o),
        .lsu_iq_ready_i(lsu_iq_ready_i),
        .lsu_iq_resp_o (lsu_iq_resp_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic iq_lsu_pkg_t mk_req(input logic [1:0] msize, input logic msigned,
                                           input logic [31:0] vaddr, input logic [31:0] wdata,
                                           input logic [3:0] strb);
        iq_lsu_pkg_t r;
        r.wid     = 4'($urandom_range(0, 15));
        r.msigned = msigned;
        r.msize   = msize;
        r.vaddr   = vaddr;
        r.wdata   = wdata;
        r.rmask   = 4'($urandom_range(0, 15));
        r.strb    = strb;
        return r;
    endfunction

    // Reference: response computed from access size, byte address range and a byte array.
    function automatic lsu_iq_pkg_t model_exec(input iq_lsu_pkg_t r);
        lsu_iq_pkg_t     e;
        longint unsigned a;
        longint unsigned lo;
        int unsigned     sz;
        int unsigned     off;
        logic [31:0]     v;
        e  = '0;
        a  = longint'(r.vaddr);
        lo = longint'(ADDR_BASE);
        sz = (r.msize == 2'd0) ? 1 : (r.msize == 2'd1) ? 2 : 4;
        v  = 32'h0;
        if ((r.vaddr % sz) != 0) begin
            e.execute_exc_info.execute_exception = 1'b1;
            e.execute_exc_info.exc_code          = 6'h09;
            e.execute_exc_info.badv              = r.vaddr;
        end else if (a < lo || a >= lo + MEM_BYTES) begin
            e.execute_exc_info.execute_exception = 1'b1;
            e.execute_exc_info.exc_code          = 6'h08;
            e.execute_exc_info.badv              = r.vaddr;
        end else if (r.strb == 4'h0) begin
            off = int'(a - lo);
            for (int i = 0; i < int'(sz); i++) v = v | (32'(mdl_mem[off + i]) << (8 * i));
            if (sz < 4 && r.msigned && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic model_store(input iq_lsu_pkg_t r);
        int unsigned base;
        base = int'(r.vaddr - ADDR_BASE) & ~3;
        for (int k = 0; k < 4; k++) begin
            if (r.strb[k]) mdl_mem[base + k] = r.wdata[8*k +: 8];
        end
    endtask

    // One clock: drive, check outputs at negedge against the model, then advance the model.
    task automatic cycle(input logic v, input iq_lsu_pkg_t r, input logic cr, input logic fl,
                         output logic acc);
        lsu_iq_pkg_t e;
        iq_lsu_valid_i = v;
        iq_lsu_req_i   = r;
        lsu_iq_ready_i = cr;
        flush          = fl;
        @(negedge clk);
        check_val("valid", 128'(lsu_iq_valid_o), 128'(exp_q.size() != 0));
        check_val("ready", 128'(iq_lsu_ready_o), 128'(exp_q.size() == 0 || cr));
        if (exp_q.size() != 0 && lsu_iq_valid_o) check_val("resp", 128'(lsu_iq_resp_o), 128'(exp_q[0]));
        acc = v && (exp_q.size() == 0 || cr);
        if (exp_q.size() != 0 && cr) last_resp = exp_q.pop_front();
        if (acc) begin
            e = model_exec(r);
            if (r.strb != 4'h0 && !e.execute_exc_info.execute_exception) model_store(r);
            if (!fl) exp_q.push_back(e);
        end
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input iq_lsu_pkg_t r);
        logic acc;
        cycle(1'b1, r, 1'b1, 1'b0, acc);
        check_val("send_accept", 128'(acc), 128'(1'b1));
    endtask

    task automatic idle();
        logic acc;
        cycle(1'b0, mk_req(2'd0, 1'b0, 32'h0, 32'h0, 4'h0), 1'b1, 1'b0, acc);
    endtask

    task automatic load_expect(input string tag, input iq_lsu_pkg_t r, input logic [31:0] exp);
        send(r);
        idle();
        check_val(tag, 128'(last_resp.rdata), 128'(exp));
        check_val({tag, "_noexc"}, 128'(last_resp.execute_exc_info.execute_exception), 128'(1'b0));
    endtask

    initial begin
        logic        acc;
        iq_lsu_pkg_t r;
        logic [31:0] va;
        rst_n          = 1'b0;
        flush          = 1'b0;
        iq_lsu_valid_i = 1'b0;
        lsu_iq_ready_i = 1'b1;
        iq_lsu_req_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_valid", 128'(lsu_iq_valid_o), 128'(1'b0));
        check_val("rst_resp", 128'(lsu_iq_resp_o), 128'(0));
        check_val("rst_ready", 128'(iq_lsu_ready_o), 128'(1'b1));
        @(posedge clk);
        #1;

        for (int w = 0; w < 64; w++) send(mk_req(2'd2, 1'b0, 32'(w * 4), $urandom, 4'hF));
        idle();

        send(mk_req(2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF));
        load_expect("t1_word", mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0), 32'hDEAD_BEEF);
        load_expect("t2_sbyte", mk_req(2'd0, 1'b1, 32'h13, 32'h0, 4'h0), 32'hFFFF_FFDE);
        load_expect("t2_ubyte", mk_req(2'd0, 1'b0, 32'h13, 32'h0, 4'h0), 32'h0000_00DE);
        load_expect("t2_uhalf", mk_req(2'd1, 1'b0, 32'h12, 32'h0, 4'h0), 32'h0000_DEAD);
        send(mk_req(2'd0, 1'b0, 32'h12, 32'h00AA_0000, 4'b0100));
        load_expect("t3_lane", mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0), 32'hDEAA_BEEF);

        send(mk_req(2'd2, 1'b0, 32'h12, 32'h0, 4'h0));
        idle();
        check_val("t4_ale_exc", 128'(last_resp.execute_exc_info), 128'({1'b1, 6'h09, 32'h12}));
        send(mk_req(2'd2, 1'b0, 32'(MEM_BYTES), 32'h0, 4'h0));
        idle();
        check_val("t4_ade_code", 128'(last_resp.execute_exc_info.exc_code), 128'(6'h08));
        send(mk_req(2'd2, 1'b0, 32'h11, 32'h1234_5678, 4'hF));
        idle();
        check_val("t4_st_exc", 128'(last_resp.execute_exc_info.execute_exception), 128'(1'b1));
        load_expect("t4_unchanged", mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0), 32'hDEAA_BEEF);

        send(mk_req(2'd2, 1'b0, 32'h10, 32'h0, 4'h0));
        r = mk_req(2'd2, 1'b0, 32'h14, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, r, 1'b0, 1'b0, acc);
            check_val("t5_stall", 128'(acc), 128'(1'b0));
        end
        cycle(1'b1, r, 1'b1, 1'b0, acc);
        check_val("t5_release", 128'(acc), 128'(1'b1));

        cycle(1'b1, mk_req(2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 4'hF), 1'b1, 1'b1, acc);
        check_val("t6_flush_acc", 128'(acc), 128'(1'b1));
        @(negedge clk);
        check_val("t6_no_resp", 128'(lsu_iq_valid_o), 128'(1'b0));
        @(posedge clk);
        #1;
        load_expect("t6_store_kept", mk_req(2'd2, 1'b0, 32'h20, 32'h0, 4'h0), 32'hCAFE_F00D);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0:       va = 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
                1:       va = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: va = 32'($urandom_range(0, 255));
            endcase
            r = mk_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), va, $urandom,
                       ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
            cycle(($urandom_range(0, 9) < 8), r, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), acc);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
